// File: rtl/prim_lfsr_bank.sv
// Bank of independent right-shift Galois LFSRs sharing one tap polynomial, with
// all-zero lockup recovery and an on-line maximal-length period checker per channel.
module prim_lfsr_bank #(
  parameter int unsigned       NumCh       = 4,
  parameter int unsigned       LfsrDw      = 16,
  parameter int unsigned       OutDw       = 8,
  parameter logic [LfsrDw-1:0] Poly        = LfsrDw'(16'hB400),
  parameter logic [LfsrDw-1:0] DefaultSeed = LfsrDw'(16'h0001)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumCh-1:0]          en_i,
  input  logic [NumCh-1:0]          seed_load_i,
  input  logic [NumCh*LfsrDw-1:0]   seed_i,
  input  logic [NumCh-1:0]          entropy_i,
  output logic [NumCh*OutDw-1:0]    data_o,
  output logic [NumCh-1:0]          lockup_o,
  output logic [NumCh-1:0]          period_done_o,
  output logic [NumCh-1:0]          period_err_o
);

  // Step count of the last state in a maximal-length period (2^LfsrDw - 1).
  localparam logic [LfsrDw-1:0] PeriodLast = '1;

  function automatic logic [LfsrDw-1:0] lfsr_step(input logic [LfsrDw-1:0] st,
                                                  input logic              ent);
    lfsr_step = (st >> 1) ^ ({LfsrDw{st[0]}} & Poly) ^ {{(LfsrDw-1){1'b0}}, ent};
  endfunction

  logic [LfsrDw-1:0] st_p0    [NumCh];
  logic [LfsrDw-1:0] ref_p0   [NumCh];
  logic [LfsrDw-1:0] cnt_p0   [NumCh];
  logic [NumCh-1:0]  taint_p0;
  logic [NumCh-1:0]  lockup_p1;
  logic [NumCh-1:0]  done_p1;
  logic [NumCh-1:0]  err_p1;

  logic [LfsrDw-1:0] nxt      [NumCh];
  logic [LfsrDw-1:0] cnt_inc  [NumCh];
  logic [NumCh-1:0]  taint_nxt;
  logic [NumCh-1:0]  hit_ref;
  logic [NumCh-1:0]  hit_last;

  always_comb begin
    for (int c = 0; c < NumCh; c++) begin
      nxt[c]       = lfsr_step(st_p0[c], entropy_i[c]);
      cnt_inc[c]   = cnt_p0[c] + LfsrDw'(1);
      taint_nxt[c] = taint_p0[c] | entropy_i[c];
      hit_ref[c]   = (nxt[c] == ref_p0[c]);
      hit_last[c]  = (cnt_inc[c] == PeriodLast);
    end
  end

  // Stage p0: channel state and period bookkeeping; p1 flags registered alongside.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NumCh; c++) begin
        st_p0[c]  <= DefaultSeed;
        ref_p0[c] <= DefaultSeed;
        cnt_p0[c] <= '0;
      end
      taint_p0  <= '0;
      lockup_p1 <= '0;
      done_p1   <= '0;
      err_p1    <= '0;
    end else begin
      for (int c = 0; c < NumCh; c++) begin
        lockup_p1[c] <= 1'b0;
        done_p1[c]   <= 1'b0;
        if (seed_load_i[c]) begin
          st_p0[c]    <= seed_i[c*LfsrDw +: LfsrDw];
          ref_p0[c]   <= seed_i[c*LfsrDw +: LfsrDw];
          cnt_p0[c]   <= '0;
          taint_p0[c] <= 1'b0;
          err_p1[c]   <= 1'b0;
        end else if (st_p0[c] == '0) begin
          st_p0[c]     <= DefaultSeed;
          ref_p0[c]    <= DefaultSeed;
          cnt_p0[c]    <= '0;
          taint_p0[c]  <= 1'b0;
          lockup_p1[c] <= 1'b1;
        end else if (en_i[c]) begin
          st_p0[c]    <= nxt[c];
          taint_p0[c] <= taint_nxt[c];
          // Any entropy injected since the last (re)seed makes the period meaningless.
          if (taint_nxt[c]) begin
            cnt_p0[c] <= '0;
          end else if (hit_ref[c] && hit_last[c]) begin
            done_p1[c] <= 1'b1;
            cnt_p0[c]  <= '0;
          end else if (hit_ref[c] || hit_last[c]) begin
            err_p1[c] <= 1'b1;
            cnt_p0[c] <= '0;
          end else begin
            cnt_p0[c] <= cnt_inc[c];
          end
        end
      end
    end
  end

  for (genvar c = 0; c < NumCh; c++) begin : g_out
    assign data_o[c*OutDw +: OutDw] = st_p0[c][OutDw-1:0];
  end

  assign lockup_o      = lockup_p1;
  assign period_done_o = done_p1;
  assign period_err_o  = err_p1;

endmodule

// File: tb/tb_prim_lfsr_bank.sv
// Directed bench for prim_lfsr_bank: two 4-bit configurations and the default 16-bit bank.
module tb_prim_lfsr_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // u_a: 2 channels, 4-bit maximal polynomial x^4+x^3+1
  logic [1:0]  a_en = '0, a_load = '0, a_ent = '0;
  logic [7:0]  a_seed = '0;
  logic [7:0]  a_data;
  logic [1:0]  a_lock, a_done, a_err;
  // u_b: 1 channel, degenerate polynomial with period 4
  logic [0:0]  b_en = '0, b_load = '0, b_ent = '0;
  logic [3:0]  b_seed = '0;
  logic [3:0]  b_data;
  logic [0:0]  b_lock, b_done, b_err;
  // u_d: default parameters
  logic [3:0]  d_en = '0, d_load = '0, d_ent = '0;
  logic [63:0] d_seed = '0;
  logic [31:0] d_data;
  logic [3:0]  d_lock, d_done, d_err;

  prim_lfsr_bank #(.NumCh(2), .LfsrDw(4), .OutDw(4), .Poly(4'hC), .DefaultSeed(4'h1)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(a_en), .seed_load_i(a_load), .seed_i(a_seed),
    .entropy_i(a_ent), .data_o(a_data), .lockup_o(a_lock), .period_done_o(a_done),
    .period_err_o(a_err));

  prim_lfsr_bank #(.NumCh(1), .LfsrDw(4), .OutDw(4), .Poly(4'h8), .DefaultSeed(4'h1)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(b_en), .seed_load_i(b_load), .seed_i(b_seed),
    .entropy_i(b_ent), .data_o(b_data), .lockup_o(b_lock), .period_done_o(b_done),
    .period_err_o(b_err));

  prim_lfsr_bank u_d (
    .clk_i(clk), .rst_i(rst), .en_i(d_en), .seed_load_i(d_load), .seed_i(d_seed),
    .entropy_i(d_ent), .data_o(d_data), .lockup_o(d_lock), .period_done_o(d_done),
    .period_err_o(d_err));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (a_data !== 8'h11 || a_lock !== 2'b0 || a_done !== 2'b0 || a_err !== 2'b0) begin
      bad++;
      $display("FAIL reset_a: data=%h lock=%b done=%b err=%b, want 11/00/00/00",
               a_data, a_lock, a_done, a_err);
    end
    total++;
    if (b_data !== 4'h1 || b_lock !== 1'b0 || b_done !== 1'b0 || b_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: data=%h lock=%b done=%b err=%b, want 1/0/0/0",
               b_data, b_lock, b_done, b_err);
    end
    total++;
    if (d_data !== 32'h01010101 || d_lock !== 4'h0 || d_done !== 4'h0 || d_err !== 4'h0) begin
      bad++;
      $display("FAIL reset_d: data=%h lock=%h done=%h err=%h, want 01010101/0/0/0",
               d_data, d_lock, d_done, d_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_max_period();
    logic [3:0] exp_seq [16] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                 4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};
    a_load = 2'b01; a_seed = 8'h01;
    tick();
    a_load = 2'b00;
    total++;
    if (a_data[3:0] !== 4'h1) begin
      bad++;
      $display("FAIL max_load: data=%h want 1", a_data[3:0]);
    end
    a_en = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      tick();
      total++;
      if (a_data[3:0] !== exp_seq[k % 15] || a_done[0] !== (k == 15) || a_err[0] !== 1'b0) begin
        bad++;
        $display("FAIL max_step%0d: data=%h done=%b err=%b, want %h/%b/0",
                 k, a_data[3:0], a_done[0], a_err[0], exp_seq[k % 15], (k == 15));
      end
    end
    a_en = 2'b00;
    total++;
    if (a_data[7:4] !== 4'h1 || a_done[1] !== 1'b0) begin
      bad++;
      $display("FAIL max_idle_ch1: data=%h done=%b, want 1/0", a_data[7:4], a_done[1]);
    end
  endtask

  task automatic test_short_period();
    logic [3:0] exp_seq [6] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4};
    b_load = 1'b1; b_seed = 4'h1;
    tick();
    b_load = 1'b0; b_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++;
      if (b_data !== exp_seq[k-1] || b_err[0] !== (k >= 4) || b_done[0] !== 1'b0) begin
        bad++;
        $display("FAIL short_step%0d: data=%h err=%b done=%b, want %h/%b/0",
                 k, b_data, b_err[0], b_done[0], exp_seq[k-1], (k >= 4));
      end
    end
    b_en = 1'b0; b_load = 1'b1; b_seed = 4'h5;
    tick();
    b_load = 1'b0;
    total++;
    if (b_err[0] !== 1'b0 || b_data !== 4'h5) begin
      bad++;
      $display("FAIL short_reload: err=%b data=%h, want 0/5", b_err[0], b_data);
    end
  endtask

  task automatic test_lockup();
    a_load = 2'b01; a_seed = 8'h00; a_en = 2'b01;
    tick();
    a_load = 2'b00;
    total++;
    if (a_data[3:0] !== 4'h0 || a_lock[0] !== 1'b0) begin
      bad++;
      $display("FAIL lock_zero_load: data=%h lock=%b, want 0/0", a_data[3:0], a_lock[0]);
    end
    tick();
    total++;
    if (a_data[3:0] !== 4'h1 || a_lock !== 2'b01) begin
      bad++;
      $display("FAIL lock_recover: data=%h lock=%b, want 1/01", a_data[3:0], a_lock);
    end
    tick();
    a_en = 2'b00;
    total++;
    if (a_data[3:0] !== 4'hC || a_lock !== 2'b00) begin
      bad++;
      $display("FAIL lock_after: data=%h lock=%b, want C/00", a_data[3:0], a_lock);
    end
  endtask

  task automatic test_entropy();
    int flags;
    int done_at;
    a_load = 2'b01; a_seed = 8'h01;
    tick();
    a_load = 2'b00; a_en = 2'b01;
    tick(); tick(); tick();
    a_ent = 2'b01;
    tick();
    a_ent = 2'b00;
    total++;
    if (a_data[3:0] !== 4'hC) begin
      bad++;
      $display("FAIL ent_step: data=%h want C", a_data[3:0]);
    end
    flags = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      flags += int'(a_done[0]) + int'(a_err[0]);
    end
    total++;
    if (flags !== 0) begin
      bad++;
      $display("FAIL ent_tainted: flag pulses=%0d want 0", flags);
    end
    a_en = 2'b00; a_load = 2'b01; a_seed = 8'h01;
    tick();
    a_load = 2'b00; a_en = 2'b01;
    done_at = 0; flags = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (a_done[0]) begin
        flags++;
        done_at = k;
      end
    end
    a_en = 2'b00;
    total++;
    if (done_at !== 15 || flags !== 1 || a_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL ent_clean: done at %0d count %0d err %b, want 15/1/0",
               done_at, flags, a_err[0]);
    end
  endtask

  task automatic test_back_to_back();
    int done_at;
    a_load = 2'b01; a_seed = 8'h01;
    tick();
    a_en = 2'b11; a_load = 2'b10; a_seed = 8'h90;
    tick();
    a_load = 2'b00;
    total++;
    if (a_data !== 8'h9C) begin
      bad++;
      $display("FAIL b2b_load_vs_step: data=%h want 9C", a_data);
    end
    tick();
    total++;
    if (a_data !== 8'h86) begin
      bad++;
      $display("FAIL b2b_both_step: data=%h want 86", a_data);
    end
    b_load = 1'b1; b_seed = 4'h1;
    tick();
    b_load = 1'b0; b_en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    b_en = 1'b0;
    total++;
    if (b_err[0] !== 1'b1) begin
      bad++;
      $display("FAIL b2b_err_set: err=%b want 1", b_err[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_en = 2'b00;
    total++;
    if (a_data !== 8'h11 || a_lock !== 2'b0 || a_done !== 2'b0 || a_err !== 2'b0 ||
        b_err !== 1'b0 || b_data !== 4'h1) begin
      bad++;
      $display("FAIL b2b_mid_reset: a=%h/%b/%b/%b b=%h/%b, want 11/00/00/00 1/0",
               a_data, a_lock, a_done, a_err, b_data, b_err);
    end
    a_en = 2'b01;
    done_at = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (a_done[0] && done_at == 0) done_at = k;
    end
    a_en = 2'b00;
    total++;
    if (done_at !== 15 || a_err[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_post_reset_period: done at %0d err %b, want 15/0", done_at, a_err[0]);
    end
  endtask

  task automatic test_independent();
    int seen [4];
    int ndone [4];
    int exp_at [4] = '{65535, 65535, 65535, 65555};
    logic [3:0] err_acc = '0;
    logic [3:0] lock_acc = '0;
    d_seed = {16'hFFFF, 16'h1234, 16'hACE1, 16'h0001};
    d_load = 4'hF;
    tick();
    d_load = 4'h0;
    total++;
    if (d_data !== 32'hFF34E101) begin
      bad++;
      $display("FAIL ind_load: data=%h want FF34E101", d_data);
    end
    for (int c = 0; c < 4; c++) begin
      seen[c] = 0;
      ndone[c] = 0;
    end
    d_en = 4'b0111;
    for (int n = 1; n <= 65600; n++) begin
      tick();
      if (n == 1) begin
        total++;
        if (d_data !== 32'hFF1A7000) begin
          bad++;
          $display("FAIL ind_first_step: data=%h want FF1A7000", d_data);
        end
      end
      if (n == 20) d_en = 4'hF;
      for (int c = 0; c < 4; c++) begin
        if (d_done[c]) begin
          ndone[c]++;
          if (seen[c] == 0) seen[c] = n;
        end
      end
      err_acc |= d_err;
      lock_acc |= d_lock;
    end
    d_en = 4'h0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (seen[c] !== exp_at[c] || ndone[c] !== 1) begin
        bad++;
        $display("FAIL ind_period_ch%0d: done at %0d count %0d, want %0d/1",
                 c, seen[c], ndone[c], exp_at[c]);
      end
    end
    total++;
    if (err_acc !== 4'h0 || lock_acc !== 4'h0) begin
      bad++;
      $display("FAIL ind_flags: err=%h lock=%h, want 0/0", err_acc, lock_acc);
    end
  endtask

  initial begin
    test_reset();
    test_max_period();
    test_short_period();
    test_lockup();
    test_entropy();
    test_back_to_back();
    test_independent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
